count_bin_display: RTL and testbench
====================================

# count_bin_display

Parametrised binary counter with a programmable rate prescaler, up/down counting, synchronous load, wrap or saturate overflow mode, and registered active-low seven-segment drive for a configurable number of hex digits. It sits beside the Qsys system in the board top level, taking CLOCK_50, slide-switch controls and load data, and driving HEX digits and LEDR directly. It generalises the fixed two-digit counter display to any width, digit count and count rate.

## Interface
Parameters:
- WIDTH, 8: counter width in bits (1..32).
- DIGITS, 2: number of seven-segment digits driven. DIGITS*4 >= WIDTH is required; elaboration fails otherwise.
- PRESCALE, 50000000: CLOCK_50 cycles per count step (>= 1).
- SATURATE, 0: overflow mode. 0 = wrap, 1 = hold at the limit.

Ports:
- CLOCK_50  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable. While low, both the prescaler and the counter hold.
- up_dn  in  1  direction. 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value written to the counter on load.
- count  out  WIDTH  current counter value, registered.
- step  out  1  one-cycle pulse marking the cycle in which count took a step.
- limit  out  1  one-cycle pulse on a wrap (SATURATE=0) or on a blocked step at the limit (SATURATE=1).
- hex  out  7*DIGITS  active-low segments. Digit i occupies hex[7i+6:7i]; bit 0 = a through bit 6 = g.
- leds  out  WIDTH  copy of count, registered alongside hex.

## Operation
- Prescaler is a register `pre`, range 0..PRESCALE-1, reset to 0.
  - When en=1: if pre==PRESCALE-1, pre returns to 0 and an internal tick is raised; otherwise pre increments.
  - When PRESCALE=1, tick is asserted on every enabled cycle.
- Counter update on tick:
  - up_dn=1 and count<max: count+1.
  - up_dn=0 and count>0: count-1.
  - At max going up: wraps to 0 if SATURATE=0; holds at max if SATURATE=1.
  - At 0 going down: wraps to max if SATURATE=0; holds at 0 if SATURATE=1.
  - max = 2^WIDTH-1. Arithmetic is modulo 2^WIDTH.
- limit pulses in the cycle after any tick that wrapped or was blocked.
- step pulses in the cycle after any tick where count changed.
- Load:
  - count <= load_value and pre <= 0, regardless of en.
  - load has priority over a coincident tick; that tick is discarded, and step and limit stay low.
- up_dn may change at any time; it is sampled only on tick cycles.
- Hex decode:
  - Digit i shows nibble count[4i+3:4i]. Bits above WIDTH-1 are zero-padded.
  - Standard 0-F glyphs, inverted (active-low). Examples: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
- Precedence: reset > load > tick > hold.

## Timing
- Reset values: count=0, pre=0, step=0, limit=0, leds=0, hex = 7'h40 on every digit.
- Reset asserted mid-period clears pre. The first tick after release comes PRESCALE enabled cycles later.
- A tick in cycle N updates count, step and limit at edge N+1. hex and leds update at edge N+2, i.e. one register stage behind count.
- A load in cycle N makes count=load_value at edge N+1 and hex at edge N+2.
- Sustained en=1 yields exactly one tick every PRESCALE cycles. Deasserting en freezes the phase of pre, and counting resumes from that phase.
- step and limit are never high for more than one consecutive cycle unless PRESCALE=1.

## Test plan
- Reset: WIDTH=8, DIGITS=2, PRESCALE=4. Hold reset 3 cycles -> count=0, hex=14'h2040 (two digits of 7'h40), step=limit=0.
- Up count and wrap: SATURATE=0, PRESCALE=4, en=1, up_dn=1, load 8'hFE -> steps to FF after 4 cycles, then 00 after 4 more. limit pulses once at the FF->00 step; hex then shows 7'h40,7'h40 one cycle later.
- Saturate: SATURATE=1, load 8'h01, up_dn=0, run 12 cycles -> count 01->00 and then holds at 00. limit pulses on each of the next two ticks; step pulses only on the 01->00 step.
- Load vs tick: PRESCALE=4. Assert load with value 8'h5A in the same cycle pre==3 -> count=8'h5A, no step, pre=0. The next step to 5B arrives 4 cycles later.
- Enable gating: en low for 10 cycles while pre==2 -> count and pre unchanged. After en is restored, the next tick comes 2 cycles later.
- Wide config: WIDTH=12, DIGITS=4, PRESCALE=1, load 12'hABC -> hex digits from digit 3 down read 0,A,B,C as 7'h40,7'h08,7'h03,7'h46. The next cycle count=12'hABD.

Source files
------------

// File: rtl/count_bin_display.sv
// count_bin_display: prescaled up/down binary counter with load,
// wrap/saturate overflow, and registered active-low hex/LED drive.
// Ports: CLOCK_50, reset (sync, high), en, up_dn, load, load_value
//   -> count, step, limit, hex[7*DIGITS-1:0], leds.
module count_bin_display #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 50000000,
  parameter int SATURATE = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  step,
  output logic                  limit,
  output logic [7*DIGITS-1:0]   hex,
  output logic [WIDTH-1:0]      leds
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam int NW = DIGITS * 4;

  if (NW < WIDTH) begin : g_bad_digits
    $error("DIGITS*4 must cover WIDTH");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end

  logic [PW-1:0]       pre;
  logic                tick;
  logic                at_max;
  logic                at_zero;
  logic [NW-1:0]       padded;
  logic [7*DIGITS-1:0] hex_next;

  assign tick    = en && (pre == PRE_LAST);
  assign at_max  = &count;
  assign at_zero = ~|count;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
      pre   <= '0;
      step  <= 1'b0;
      limit <= 1'b0;
    end else begin
      step  <= 1'b0;
      limit <= 1'b0;
      if (load) begin
        count <= load_value;
        pre   <= '0;
      end else if (en) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          if (up_dn) begin
            if (!at_max) begin
              count <= count + 1'b1;
              step  <= 1'b1;
            end else if (SATURATE != 0) begin
              limit <= 1'b1;
            end else begin
              count <= '0;
              step  <= 1'b1;
              limit <= 1'b1;
            end
          end else begin
            if (!at_zero) begin
              count <= count - 1'b1;
              step  <= 1'b1;
            end else if (SATURATE != 0) begin
              limit <= 1'b1;
            end else begin
              count <= '1;
              step  <= 1'b1;
              limit <= 1'b1;
            end
          end
        end
      end
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Zero-extend count to a whole number of nibbles.
  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = count;
  end

  always_comb begin
    hex_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hex_next[7*i +: 7] = seg(padded[4*i +: 4]);
    end
  end

  // Display is one register stage behind count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hex  <= {DIGITS{7'h40}};
      leds <= '0;
    end else begin
      hex  <= hex_next;
      leds <= count;
    end
  end

endmodule

// File: tb/tb_count_bin_display.sv
// tb_count_bin_display: checks three counter configurations
// against a behavioural model plus directed literal vectors.
module tb_count_bin_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  // A: W8 D2 P4 wrap.  B: W8 D2 P4 saturate.  C: W12 D4 P1 wrap.
  logic        rst_a, en_a, up_a, ld_a;
  logic [7:0]  lv_a, cnt_a, leds_a;
  logic        step_a, lim_a;
  logic [13:0] hex_a;

  logic        rst_b, en_b, up_b, ld_b;
  logic [7:0]  lv_b, cnt_b, leds_b;
  logic        step_b, lim_b;
  logic [13:0] hex_b;

  logic        rst_c, en_c, up_c, ld_c;
  logic [11:0] lv_c, cnt_c, leds_c;
  logic        step_c, lim_c;
  logic [27:0] hex_c;

  count_bin_display #(.WIDTH(8), .DIGITS(2), .PRESCALE(4), .SATURATE(0))
  u_a (.CLOCK_50(clk), .reset(rst_a), .en(en_a), .up_dn(up_a),
       .load(ld_a), .load_value(lv_a), .count(cnt_a), .step(step_a),
       .limit(lim_a), .hex(hex_a), .leds(leds_a));

  count_bin_display #(.WIDTH(8), .DIGITS(2), .PRESCALE(4), .SATURATE(1))
  u_b (.CLOCK_50(clk), .reset(rst_b), .en(en_b), .up_dn(up_b),
       .load(ld_b), .load_value(lv_b), .count(cnt_b), .step(step_b),
       .limit(lim_b), .hex(hex_b), .leds(leds_b));

  count_bin_display #(.WIDTH(12), .DIGITS(4), .PRESCALE(1), .SATURATE(0))
  u_c (.CLOCK_50(clk), .reset(rst_c), .en(en_c), .up_dn(up_c),
       .load(ld_c), .load_value(lv_c), .count(cnt_c), .step(step_c),
       .limit(lim_c), .hex(hex_c), .leds(leds_c));

  typedef struct {
    int cnt;
    int pre;
    bit step;
    bit lim;
    int shown;
  } mst_t;

  mst_t ma = '{0, 0, 1'b0, 1'b0, 0};
  mst_t mb = '{0, 0, 1'b0, 1'b0, 0};
  mst_t mc = '{0, 0, 1'b0, 1'b0, 0};

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // One clock of the counter, from the behavioural rules.
  function automatic mst_t mstep(mst_t s, bit rst, bit en, bit up,
                                 bit ld, int lv, int w, int ps, bit sat);
    mst_t n;
    int mx;
    int tgt;
    n = s;
    mx = (1 << w) - 1;
    n.shown = s.cnt;
    n.step = 1'b0;
    n.lim = 1'b0;
    if (rst) begin
      n.cnt = 0;
      n.pre = 0;
      n.shown = 0;
    end else if (ld) begin
      n.cnt = lv;
      n.pre = 0;
    end else if (en) begin
      if (s.pre == ps - 1) begin
        n.pre = 0;
        tgt = up ? s.cnt + 1 : s.cnt - 1;
        if (tgt < 0 || tgt > mx) begin
          n.lim = 1'b1;
          if (!sat) n.cnt = tgt & mx;
        end else begin
          n.cnt = tgt;
        end
        n.step = (n.cnt != s.cnt);
      end else begin
        n.pre = s.pre + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [27:0] hexexp(int v, int digits);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < digits; i++)
      r[7*i +: 7] = glyph[(v >> (4*i)) & 15];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= mstep(ma, rst_a, en_a, up_a, ld_a, int'(lv_a), 8, 4, 1'b0);
    mb <= mstep(mb, rst_b, en_b, up_b, ld_b, int'(lv_b), 8, 4, 1'b1);
    mc <= mstep(mc, rst_c, en_c, up_c, ld_c, int'(lv_c), 12, 1, 1'b0);
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_count", 32'(cnt_a), ma.cnt);
      chk("a_step", 32'(step_a), 32'(ma.step));
      chk("a_limit", 32'(lim_a), 32'(ma.lim));
      chk("a_leds", 32'(leds_a), ma.shown);
      chk("a_hex", 32'(hex_a), 32'(hexexp(ma.shown, 2)));
      chk("b_count", 32'(cnt_b), mb.cnt);
      chk("b_step", 32'(step_b), 32'(mb.step));
      chk("b_limit", 32'(lim_b), 32'(mb.lim));
      chk("b_leds", 32'(leds_b), mb.shown);
      chk("b_hex", 32'(hex_b), 32'(hexexp(mb.shown, 2)));
      chk("c_count", 32'(cnt_c), mc.cnt);
      chk("c_step", 32'(step_c), 32'(mc.step));
      chk("c_limit", 32'(lim_c), 32'(mc.lim));
      chk("c_leds", 32'(leds_c), mc.shown);
      chk("c_hex", 32'(hex_c), 32'(hexexp(mc.shown, 4)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_a = 1; en_a = 0; up_a = 1; ld_a = 0; lv_a = '0;
    rst_b = 1; en_b = 0; up_b = 1; ld_b = 0; lv_b = '0;
    rst_c = 1; en_c = 0; up_c = 1; ld_c = 0; lv_c = '0;
    cyc(3);
    chk("lit_rst_count", 32'(cnt_a), 32'h0);
    chk("lit_rst_hex", 32'(hex_a), 32'h2040);
    chk("lit_rst_step", 32'(step_a), 32'h0);
    chk("lit_rst_limit", 32'(lim_a), 32'h0);
    chk("lit_rst_hex_c", 32'(hex_c), 32'h0810_2040);
    rst_a = 0; rst_b = 0; rst_c = 0;

    // Up count and wrap.
    ld_a = 1; lv_a = 8'hFE; en_a = 1; up_a = 1;
    cyc(1); ld_a = 0;
    chk("lit_wrap_load", 32'(cnt_a), 32'hFE);
    cyc(3);
    chk("lit_wrap_wait", 32'(cnt_a), 32'hFE);
    cyc(1);
    chk("lit_wrap_ff", 32'(cnt_a), 32'hFF);
    chk("lit_wrap_ff_step", 32'(step_a), 32'h1);
    cyc(4);
    chk("lit_wrap_00", 32'(cnt_a), 32'h00);
    chk("lit_wrap_limit", 32'(lim_a), 32'h1);
    cyc(1);
    chk("lit_wrap_hex", 32'(hex_a), 32'h2040);
    chk("lit_wrap_limit_off", 32'(lim_a), 32'h0);

    // Load coincident with the tick cycle (pre==3).
    cyc(2);
    ld_a = 1; lv_a = 8'h5A;
    cyc(1); ld_a = 0;
    chk("lit_ldtick_count", 32'(cnt_a), 32'h5A);
    chk("lit_ldtick_step", 32'(step_a), 32'h0);
    chk("lit_ldtick_limit", 32'(lim_a), 32'h0);
    cyc(3);
    chk("lit_ldtick_wait", 32'(cnt_a), 32'h5A);
    cyc(1);
    chk("lit_ldtick_5b", 32'(cnt_a), 32'h5B);

    // Enable gating with pre==2.
    cyc(2);
    en_a = 0;
    cyc(10);
    chk("lit_en_hold", 32'(cnt_a), 32'h5B);
    en_a = 1;
    cyc(1);
    chk("lit_en_resume1", 32'(cnt_a), 32'h5B);
    cyc(1);
    chk("lit_en_resume2", 32'(cnt_a), 32'h5C);

    // Free run with direction changes, loads and a mid-period reset.
    for (int i = 0; i < 60; i++) begin
      if (i % 7 == 0) up_a = ~up_a;
      ld_a = (i == 23);
      lv_a = 8'h01;
      rst_a = (i == 41);
      en_a = (i % 13 != 5);
      cyc(1);
    end
    ld_a = 0; rst_a = 0; en_a = 0;

    // Saturate mode, counting down from 1.
    ld_b = 1; lv_b = 8'h01; up_b = 0; en_b = 1;
    cyc(1); ld_b = 0;
    chk("lit_sat_load", 32'(cnt_b), 32'h01);
    cyc(4);
    chk("lit_sat_00", 32'(cnt_b), 32'h00);
    chk("lit_sat_step", 32'(step_b), 32'h1);
    chk("lit_sat_nolim", 32'(lim_b), 32'h0);
    cyc(4);
    chk("lit_sat_hold", 32'(cnt_b), 32'h00);
    chk("lit_sat_lim1", 32'(lim_b), 32'h1);
    chk("lit_sat_nostep", 32'(step_b), 32'h0);
    cyc(1);
    chk("lit_sat_lim_off", 32'(lim_b), 32'h0);
    cyc(3);
    chk("lit_sat_lim2", 32'(lim_b), 32'h1);
    ld_b = 1; lv_b = 8'hFE; up_b = 1;
    cyc(1); ld_b = 0;
    cyc(16);
    chk("lit_sat_top", 32'(cnt_b), 32'hFF);
    en_b = 0;

    // Wide configuration, PRESCALE=1.
    ld_c = 1; lv_c = 12'hABC; en_c = 1; up_c = 1;
    cyc(1); ld_c = 0;
    chk("lit_wide_load", 32'(cnt_c), 32'hABC);
    cyc(1);
    chk("lit_wide_next", 32'(cnt_c), 32'hABD);
    chk("lit_wide_hex", 32'(hex_c),
        32'({7'h40, 7'h08, 7'h03, 7'h46}));
    ld_c = 1; lv_c = 12'h001; up_c = 0;
    cyc(1); ld_c = 0;
    chk("lit_wide_ld1", 32'(cnt_c), 32'h001);
    chk("lit_wide_ld1_step", 32'(step_c), 32'h0);
    cyc(1);
    chk("lit_wide_000", 32'(cnt_c), 32'h000);
    cyc(1);
    chk("lit_wide_fff", 32'(cnt_c), 32'hFFF);
    chk("lit_wide_limit", 32'(lim_c), 32'h1);
    cyc(10);
    en_c = 0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
